// File: rtl/sntrup_pkg.sv
// Shared constants and types for the short-polynomial encode path.
// Holds ring size, RAM geometry, ternary coefficient words and the encoder FSM states.
package sntrup_pkg;

  localparam int P      = 757;
  localparam int COEF_W = 13;
  localparam int ADDR_W = 11;
  localparam int NBYTES = (P + 3) / 4;

  localparam logic [COEF_W-1:0] COEF_M1 = 13'h1FFF;
  localparam logic [COEF_W-1:0] COEF_Z  = 13'h0000;
  localparam logic [COEF_W-1:0] COEF_P1 = 13'h0001;

  localparam logic [ADDR_W-1:0] IDLE_ADDR = 11'h7FF;
  localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(P - 1);
  localparam logic [7:0]        LAST_BYTE = 8'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // cur is the coefficient arriving this cycle: lane 3 of a full byte, lane 0 of the tail byte.
  function automatic logic [7:0] pack_byte(input logic [1:0] cur,
                                           input logic [5:0] lanes,
                                           input logic       tail);
    return tail ? {6'b000000, cur} : {cur, lanes};
  endfunction

endpackage

// File: rtl/small_coef_decode.sv
// Maps a 13-bit two's-complement ternary coefficient to its 2-bit code f+1.
// Words outside {-1,0,1} encode as 0 (code 1) and raise invalid.
module small_coef_decode
  import sntrup_pkg::*;
(
  input  logic [COEF_W-1:0] coef,
  output logic [1:0]        code,
  output logic              invalid
);

  // Ternary word to code lookup
  always_comb begin
    code    = 2'd1;
    invalid = 1'b0;
    case (coef)
      COEF_M1: begin
        code    = 2'd0;
        invalid = 1'b0;
      end
      COEF_Z: begin
        code    = 2'd1;
        invalid = 1'b0;
      end
      COEF_P1: begin
        code    = 2'd2;
        invalid = 1'b0;
      end
      default: begin
        code    = 2'd1;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/small_encode.sv
// Reads a ternary polynomial from the coefficient RAM and streams the Small_encode
// byte string (four 2-bit codes per byte) over a valid/ready interface.
module small_encode
  import sntrup_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address_o,
  input  logic [COEF_W-1:0] mem_data_i,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              coef_err
);

  state_t            state_r, state_s;
  logic [7:0]        byte_cnt_r, byte_cnt_s;
  logic [ADDR_W-1:0] coef_cnt_r, coef_cnt_s;
  logic [ADDR_W-1:0] mem_address_s;
  logic              rd_pend_r, rd_pend_s;
  logic [1:0]        rd_lane_r, rd_lane_s;
  logic [5:0]        lanes_r, lanes_s;
  logic              busy_s, done_s, out_valid_s, out_last_s, coef_err_s;
  logic [7:0]        out_byte_s;
  logic [1:0]        code_s;
  logic              invalid_s;
  logic              last_byte_s;
  logic              last_addr_s;

  small_coef_decode u_decode (
    .coef    (mem_data_i),
    .code    (code_s),
    .invalid (invalid_s)
  );

  assign last_byte_s = (byte_cnt_r == LAST_BYTE);
  assign last_addr_s = (coef_cnt_r == LAST_COEF) || (coef_cnt_r[1:0] == 2'd3);

  // Next-state and next-register computation
  always_comb begin
    state_s       = state_r;
    byte_cnt_s    = byte_cnt_r;
    coef_cnt_s    = coef_cnt_r;
    mem_address_s = mem_address_o;
    rd_pend_s     = 1'b0;
    rd_lane_s     = rd_lane_r;
    lanes_s       = lanes_r;
    busy_s        = busy;
    done_s        = 1'b0;
    out_valid_s   = out_valid;
    out_last_s    = out_last;
    out_byte_s    = out_byte;
    coef_err_s    = coef_err | (rd_pend_r & invalid_s);

    // RAM data lands one cycle after its address; lane 3 is consumed directly in DRAIN.
    if (rd_pend_r) begin
      case (rd_lane_r)
        2'd0:    lanes_s[1:0] = code_s;
        2'd1:    lanes_s[3:2] = code_s;
        2'd2:    lanes_s[5:4] = code_s;
        default: lanes_s      = lanes_r;
      endcase
    end else begin
      lanes_s = lanes_r;
    end

    case (state_r)
      ST_IDLE: begin
        mem_address_s = IDLE_ADDR;
        if (start) begin
          state_s       = ST_FETCH;
          busy_s        = 1'b1;
          coef_err_s    = 1'b0;
          byte_cnt_s    = 8'd0;
          coef_cnt_s    = {ADDR_W{1'b0}};
          mem_address_s = {ADDR_W{1'b0}};
          lanes_s       = 6'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        rd_pend_s = 1'b1;
        rd_lane_s = coef_cnt_r[1:0];
        if (last_addr_s) begin
          state_s = ST_DRAIN;
        end else begin
          coef_cnt_s    = coef_cnt_r + 11'd1;
          mem_address_s = coef_cnt_r + 11'd1;
        end
      end
      ST_DRAIN: begin
        out_byte_s  = pack_byte(code_s, lanes_r, last_byte_s);
        out_valid_s = 1'b1;
        out_last_s  = last_byte_s;
        state_s     = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          if (last_byte_s) begin
            state_s       = ST_FINISH;
            done_s        = 1'b1;
            busy_s        = 1'b0;
            coef_cnt_s    = {ADDR_W{1'b0}};
            mem_address_s = IDLE_ADDR;
          end else begin
            state_s       = ST_FETCH;
            byte_cnt_s    = byte_cnt_r + 8'd1;
            coef_cnt_s    = coef_cnt_r + 11'd1;
            mem_address_s = coef_cnt_r + 11'd1;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_FINISH: begin
        state_s       = ST_IDLE;
        mem_address_s = IDLE_ADDR;
      end
      default: begin
        state_s       = ST_IDLE;
        busy_s        = 1'b0;
        out_valid_s   = 1'b0;
        out_last_s    = 1'b0;
        mem_address_s = IDLE_ADDR;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r    <= 8'd0;
      coef_cnt_r    <= {ADDR_W{1'b0}};
      mem_address_o <= IDLE_ADDR;
      rd_pend_r     <= 1'b0;
      rd_lane_r     <= 2'd0;
      lanes_r       <= 6'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_byte      <= 8'd0;
      coef_err      <= 1'b0;
    end else begin
      byte_cnt_r    <= byte_cnt_s;
      coef_cnt_r    <= coef_cnt_s;
      mem_address_o <= mem_address_s;
      rd_pend_r     <= rd_pend_s;
      rd_lane_r     <= rd_lane_s;
      lanes_r       <= lanes_s;
      busy          <= busy_s;
      done          <= done_s;
      out_valid     <= out_valid_s;
      out_last      <= out_last_s;
      out_byte      <= out_byte_s;
      coef_err      <= coef_err_s;
    end
  end

endmodule

// File: tb/tb_small_encode.sv
// Scoreboard bench for small_encode: a reference model packs the RAM contents into the
// expected byte queue at start; a monitor pops and compares on every output handshake.
module tb_small_encode;

  logic        clk, rst, start, busy, done, out_valid, out_ready, out_last, coef_err;
  logic [10:0] mem_address_o;
  logic [12:0] mem_data_i;
  logic [7:0]  out_byte;

  logic [12:0] ram [0:756];
  logic [8:0]  exp_q [$];
  int          errors = 0, checks = 0, hs_cnt = 0, done_cnt = 0;
  bit          exp_err, seen;

  small_encode dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_address_o(mem_address_o), .mem_data_i(mem_data_i),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .coef_err(coef_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous-read coefficient RAM
  always @(posedge clk)
    mem_data_i <= (mem_address_o <= 11'd756) ? ram[mem_address_o] : 13'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: compare every accepted byte against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_byte", {23'd0, out_last, out_byte}, 32'h1FF);
      end else begin
        chk($sformatf("byte%0d", hs_cnt - 1), {23'd0, out_last, out_byte}, {23'd0, exp_q.pop_front()});
      end
    end
    if (!rst && done) done_cnt++;
  end

  function automatic int ref_code(input logic [12:0] c);
    if (c == 13'h0001) return 2;
    else if (c == 13'h1FFF) return 0;
    else return 1;
  endfunction

  // reference: byte b = sum_j code(f[4b+j]) * 4^j, missing coefficients count as 0
  task automatic build_expected(output bit err);
    int v, idx;
    err = 1'b0;
    for (int b = 0; b < 190; b++) begin
      v = 0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * b + j;
        if (idx < 757) begin
          v = v + ref_code(ram[idx]) * (1 << (2 * j));
          if (ram[idx] != 13'h0000 && ram[idx] != 13'h0001 && ram[idx] != 13'h1FFF) err = 1'b1;
        end
      end
      exp_q.push_back({(b == 189) ? 1'b1 : 1'b0, 8'(v)});
    end
  endtask

  task automatic fill(input int mode);
    logic [12:0] pat [4];
    pat[0] = 13'h1FFF; pat[1] = 13'h0000; pat[2] = 13'h0001; pat[3] = 13'h1FFF;
    for (int i = 0; i < 757; i++) begin
      case (mode)
        0: ram[i] = 13'h0000;
        1: ram[i] = pat[i % 4];
        2: ram[i] = 13'h0001;
        default: ram[i] = pat[$urandom_range(0, 2)];
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prepare();
    exp_q.delete();
    build_expected(exp_err);
    hs_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit poke, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      start = poke && (i == 100 || i == 700);
      tick();
      if (done) ok = 1'b1;
    end
    if (ok && poke) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic wait_cond_hs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (hs_cnt == n) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic finish_run(input string tag, input bit rnd, input bit poke);
    bit ok;
    wait_done(8000, rnd, poke, ok);
    chk({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
    repeat (20) tick();
    chk({tag, "_handshakes"}, hs_cnt, 32'd190);
    chk({tag, "_done_pulses"}, done_cnt, 32'd1);
    chk({tag, "_left_in_queue"}, exp_q.size(), 32'd0);
    chk({tag, "_coef_err"}, {31'd0, coef_err}, {31'd0, exp_err});
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_addr"}, {21'd0, mem_address_o}, 32'd2047);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    fill(0);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_coef_err", {31'd0, coef_err}, 32'd0);
    chk("rst_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_addr", {21'd0, mem_address_o}, 32'd2047);
    tick();

    // all-zero polynomial
    fill(0); prepare();
    pulse_start();
    chk("zero_busy", {31'd0, busy}, 32'd1);
    finish_run("zero", 1'b0, 1'b0);

    // repeating -1,0,1,-1
    fill(1); prepare();
    pulse_start();
    finish_run("pattern", 1'b0, 1'b0);

    // all +1 with a 10-cycle stall on byte 7
    fill(2); prepare();
    pulse_start();
    wait_cond_hs(7, ok);
    out_ready = 1'b0;
    chk("stall_reach7", {31'd0, ok}, 32'd1);
    wait_valid(ok);
    chk("stall_valid", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_byte", {24'd0, out_byte}, 32'hAA);
      chk("stall_addr", {21'd0, mem_address_o}, 32'd31);
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    chk("stall_hs_count", hs_cnt, 32'd7);
    out_ready = 1'b1;
    finish_run("stall", 1'b0, 1'b0);

    // invalid coefficient at address 3
    fill(0); ram[3] = 13'h0005; prepare();
    pulse_start();
    wait_valid(ok);
    chk("err_first_valid", {31'd0, ok}, 32'd1);
    chk("err_set_at_byte0", {31'd0, coef_err}, 32'd1);
    finish_run("err", 1'b0, 1'b0);
    fill(0); prepare();
    pulse_start();
    chk("err_cleared_on_start", {31'd0, coef_err}, 32'd0);
    finish_run("err_clear", 1'b0, 1'b0);

    // random ternary contents with random backpressure
    for (int r = 0; r < 3; r++) begin
      fill(3); prepare();
      pulse_start();
      finish_run($sformatf("rand%0d", r), 1'b1, 1'b0);
    end

    // reset while byte 50 is waiting for a handshake
    fill(3); prepare();
    pulse_start();
    wait_cond_hs(50, ok);
    out_ready = 1'b0;
    wait_valid(ok);
    chk("rst_mid_valid", {31'd0, ok}, 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", {21'd0, mem_address_o}, 32'd2047);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_hs", hs_cnt, 32'd50);
    repeat (5) tick();
    chk("rst_mid_no_done", done_cnt, 32'd0);
    prepare();
    pulse_start();
    finish_run("after_rst", 1'b0, 1'b0);

    // start pulses while busy and in the done cycle are ignored
    fill(3); prepare();
    pulse_start();
    finish_run("start_poke", 1'b0, 1'b1);
    chk("start_poke_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
